// File: rtl/msi_cache_line.sv
`default_nettype none
// ============================================================================
// Module      : msi_cache_line
// Description : Single-line MSI-coherent private cache for one CPU node.
//               Holds the line storage, the processor-side request FSM and
//               the bus snoop logic. Several instances share one broadcast
//               snoop bus.
//               Optional feature macro: STATS_EN (hit/miss counters).
// Revision    : 1.0 - initial release
// ============================================================================
module msi_cache_line #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4,
    localparam int BUS_W = 3 + ADDR_W + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              execute_instruction,
    input  logic              instruction,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [BUS_W-1:0]  bus_out,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic              writeback,
    output logic [ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0] wb_data,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    // Line coherence states (2'b11 is never written and reads as Invalid)
    localparam logic [1:0] c_ST_INV = 2'b00;
    localparam logic [1:0] c_ST_SHR = 2'b01;
    localparam logic [1:0] c_ST_MOD = 2'b10;

    // Processor-side FSM encoding
    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_LOOKUP = 2'b01;
    localparam logic [1:0] c_WRITE  = 2'b10;
    localparam logic [1:0] c_BUS    = 2'b11;

    // Bus word bit positions
    localparam int c_RM_BIT  = BUS_W - 1;
    localparam int c_WM_BIT  = BUS_W - 2;
    localparam int c_INV_BIT = BUS_W - 3;

    logic [1:0]        r_fsm, w_fsm_next;
    logic [1:0]        r_line_state, w_line_state;
    logic [ADDR_W-1:0] r_tag, w_tag;
    logic [DATA_W-1:0] r_data, w_data;
    logic              r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_inv_path, w_inv_path;
    logic [DATA_W-1:0] r_data_out, w_data_out;
    logic              r_done, w_done;
    logic [BUS_W-1:0]  r_bus_out, w_bus_out;
    logic              r_writeback, w_writeback;
    logic [ADDR_W-1:0] r_wb_address, w_wb_address;
    logic [DATA_W-1:0] r_wb_data, w_wb_data;
    logic              w_hit_inc, w_miss_inc;

    logic w_line_valid, w_hit, w_bus_valid, w_snoop_hit, w_stall, w_latch;
    logic w_unused_bus_data;

    assign w_line_valid = (r_line_state == c_ST_SHR) || (r_line_state == c_ST_MOD);
    assign w_hit        = w_line_valid && (r_tag == r_addr);
    assign w_bus_valid  = bus_in[c_RM_BIT] | bus_in[c_WM_BIT] | bus_in[c_INV_BIT];
    assign w_snoop_hit  = w_bus_valid && w_line_valid &&
                          (bus_in[DATA_W +: ADDR_W] == r_tag);
    // Processor work yields to the snoop; IDLE touches no line state so it never stalls
    assign w_stall      = w_snoop_hit && (r_fsm != c_IDLE);
    assign w_latch      = (r_fsm == c_IDLE) && execute_instruction;
    assign w_unused_bus_data = ^bus_in[DATA_W-1:0];

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_fsm <= c_IDLE;
        else       r_fsm <= w_fsm_next;
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_next = r_fsm;
        if (!w_stall) begin
            case (r_fsm)
                c_IDLE:   if (execute_instruction) w_fsm_next = c_LOOKUP;
                c_LOOKUP: begin
                    if (w_hit && !r_instr)                      w_fsm_next = c_IDLE;
                    else if (w_hit && r_line_state == c_ST_MOD) w_fsm_next = c_WRITE;
                    else                                        w_fsm_next = c_BUS;
                end
                c_WRITE:  w_fsm_next = c_IDLE;
                default:  if (r_inv_path || fill_valid) w_fsm_next = c_IDLE;
            endcase
        end
    end

    // FSM outputs and line updates; snoop actions are applied last so they win
    always_comb begin
        w_line_state = r_line_state;
        w_tag        = r_tag;
        w_data       = r_data;
        w_inv_path   = r_inv_path;
        w_data_out   = r_data_out;
        w_done       = 1'b0;
        w_bus_out    = '0;
        w_writeback  = 1'b0;
        w_wb_address = r_wb_address;
        w_wb_data    = r_wb_data;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        if (!w_stall) begin
            case (r_fsm)
                c_LOOKUP: begin
                    if (w_hit) begin
                        w_hit_inc = 1'b1;
                        if (!r_instr) begin
                            w_data_out = r_data;
                            w_done     = 1'b1;
                        end else if (r_line_state == c_ST_MOD) begin
                            w_data = r_wdata;
                        end else begin
                            w_bus_out             = '0;
                            w_bus_out[c_INV_BIT]  = 1'b1;
                            w_bus_out[DATA_W +: ADDR_W] = r_addr;
                            w_inv_path            = 1'b1;
                        end
                    end else begin
                        w_miss_inc = 1'b1;
                        if (r_line_state == c_ST_MOD) begin
                            w_writeback  = 1'b1;
                            w_wb_address = r_tag;
                            w_wb_data    = r_data;
                        end
                        w_bus_out                   = '0;
                        w_bus_out[c_RM_BIT]         = !r_instr;
                        w_bus_out[c_WM_BIT]         = r_instr;
                        w_bus_out[DATA_W +: ADDR_W] = r_addr;
                        w_inv_path                  = 1'b0;
                    end
                end
                c_WRITE: begin
                    w_data_out = r_data;
                    w_done     = 1'b1;
                end
                c_BUS: begin
                    if (r_inv_path) begin
                        w_data       = r_wdata;
                        w_line_state = c_ST_MOD;
                        w_data_out   = r_wdata;
                        w_done       = 1'b1;
                    end else if (fill_valid) begin
                        w_tag        = r_addr;
                        w_data       = r_instr ? r_wdata : fill_data;
                        w_line_state = r_instr ? c_ST_MOD : c_ST_SHR;
                        w_data_out   = r_instr ? r_wdata : fill_data;
                        w_done       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (w_snoop_hit) begin
            if (bus_in[c_WM_BIT] || bus_in[c_INV_BIT]) begin
                if (bus_in[c_WM_BIT] && r_line_state == c_ST_MOD) begin
                    w_writeback  = 1'b1;
                    w_wb_address = r_tag;
                    w_wb_data    = r_data;
                end
                w_line_state = c_ST_INV;
            end else if (r_line_state == c_ST_MOD) begin
                w_writeback  = 1'b1;
                w_wb_address = r_tag;
                w_wb_data    = r_data;
                w_line_state = c_ST_SHR;
            end
        end
    end

    // Line storage, request latch and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_line_state <= c_ST_INV;
            r_tag        <= '0;
            r_data       <= '0;
            r_instr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_inv_path   <= 1'b0;
            r_data_out   <= '0;
            r_done       <= 1'b0;
            r_bus_out    <= '0;
            r_writeback  <= 1'b0;
            r_wb_address <= '0;
            r_wb_data    <= '0;
        end else begin
            if (w_latch) begin
                r_instr <= instruction;
                r_addr  <= address;
                r_wdata <= data_in;
            end
            r_line_state <= w_line_state;
            r_tag        <= w_tag;
            r_data       <= w_data;
            r_inv_path   <= w_inv_path;
            r_data_out   <= w_data_out;
            r_done       <= w_done;
            r_bus_out    <= w_bus_out;
            r_writeback  <= w_writeback;
            r_wb_address <= w_wb_address;
            r_wb_data    <= w_wb_data;
        end
    end

`ifdef STATS_EN
    logic [7:0] r_hit_count, r_miss_count;

    // Lookup statistics, wrapping at 255
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit_inc)  r_hit_count  <= r_hit_count + 8'd1;
            if (w_miss_inc) r_miss_count <= r_miss_count + 8'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_hit_inc | w_miss_inc;
    assign hit_count      = '0;
    assign miss_count     = '0;
`endif

    assign data_out   = r_data_out;
    assign done       = r_done;
    assign bus_out    = r_bus_out;
    assign writeback  = r_writeback;
    assign wb_address = r_wb_address;
    assign wb_data    = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_msi_cache_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_msi_cache_line
// Description : Self-checking bench for msi_cache_line: request vectors from a
//               table, data_out scoreboard, hand-written snoop, stall and
//               reset sequences. Expects STATS_EN to match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msi_cache_line;

    localparam logic [1:0] c_ST_INV = 2'b00;
    localparam logic [1:0] c_ST_SHR = 2'b01;
    localparam logic [1:0] c_ST_MOD = 2'b10;

    logic       clock, reset;
    logic       execute_instruction, instruction;
    logic [2:0] address;
    logic [3:0] data_in, data_out, fill_data, wb_data;
    logic       done, fill_valid, writeback;
    logic [9:0] bus_in, bus_out;
    logic [2:0] wb_address;
    logic [7:0] hit_count, miss_count;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb[$];

    msi_cache_line dut (
        .clock(clock), .reset(reset),
        .execute_instruction(execute_instruction), .instruction(instruction),
        .address(address), .data_in(data_in), .data_out(data_out), .done(done),
        .bus_in(bus_in), .bus_out(bus_out),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .writeback(writeback), .wb_address(wb_address), .wb_data(wb_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest queued request
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("data_out", {28'd0, data_out}, {28'd0, sb.pop_front()});
        end
    end

    typedef struct {
        logic       instr;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic [3:0] fill;
        logic [9:0] exp_bus;
        logic       exp_wb;
        logic [2:0] exp_wb_addr;
        logic [3:0] exp_wb_data;
        logic [3:0] exp_data;
        int         exp_lat;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        int k;
        logic got_done, wb_seen;
        logic [9:0] bus_seen;
        logic [2:0] wb_a;
        logic [3:0] wb_d;
        k = 0; got_done = 0; wb_seen = 0; bus_seen = '0; wb_a = '0; wb_d = '0;
        @(negedge clock);
        execute_instruction = 1'b1; instruction = v.instr;
        address = v.addr; data_in = v.wdata;
        sb.push_back(v.exp_data);
        @(negedge clock);
        execute_instruction = 1'b0;
        k = 1;
        while (!got_done && k < 20) begin
            if (bus_out != 10'd0) begin
                bus_seen = bus_out;
                if (bus_out[9] || bus_out[8]) begin
                    fill_valid = 1'b1; fill_data = v.fill;
                end
            end
            if (writeback) begin
                wb_seen = 1'b1; wb_a = wb_address; wb_d = wb_data;
            end
            if (done) got_done = 1'b1;
            else begin
                @(negedge clock);
                k++;
            end
        end
        fill_valid = 1'b0;
        if (!got_done) begin
            check("timeout", 32'd1, 32'd0);
            void'(sb.pop_back());
        end
        check("latency", k, v.exp_lat);
        check("bus_out", {22'd0, bus_seen}, {22'd0, v.exp_bus});
        check("writeback", {31'd0, wb_seen}, {31'd0, v.exp_wb});
        if (v.exp_wb) begin
            check("wb_address", {29'd0, wb_a}, {29'd0, v.exp_wb_addr});
            check("wb_data", {28'd0, wb_d}, {28'd0, v.exp_wb_data});
        end
        check("line_state", {30'd0, dut.r_line_state}, {30'd0, v.exp_state});
    endtask

    initial begin
        reset = 1'b1; execute_instruction = 1'b0; instruction = 1'b0;
        address = '0; data_in = '0; bus_in = '0; fill_valid = 1'b0; fill_data = '0;

        //          instr addr   wdata fill  bus     wb  wbA   wbD   data  lat state
        vecs[0] = '{1'b0, 3'd2, 4'h0, 4'h5, 10'h220, 1'b0, 3'd0, 4'h0, 4'h5, 3, c_ST_SHR};
        vecs[1] = '{1'b0, 3'd2, 4'h0, 4'h0, 10'h000, 1'b0, 3'd0, 4'h0, 4'h5, 2, c_ST_SHR};
        vecs[2] = '{1'b1, 3'd2, 4'hA, 4'h0, 10'h0A0, 1'b0, 3'd0, 4'h0, 4'hA, 3, c_ST_MOD};
        vecs[3] = '{1'b1, 3'd2, 4'hB, 4'h0, 10'h0A0, 1'b0, 3'd0, 4'h0, 4'hB, 3, c_ST_MOD};
        vecs[4] = '{1'b1, 3'd2, 4'hC, 4'h0, 10'h000, 1'b0, 3'd0, 4'h0, 4'hC, 3, c_ST_MOD};
        vecs[5] = '{1'b1, 3'd4, 4'hD, 4'h3, 10'h140, 1'b1, 3'd2, 4'hC, 4'hD, 3, c_ST_MOD};
        vecs[6] = '{1'b0, 3'd4, 4'h0, 4'h0, 10'h000, 1'b0, 3'd0, 4'h0, 4'hD, 2, c_ST_MOD};
        vecs[7] = '{1'b0, 3'd3, 4'h0, 4'h7, 10'h230, 1'b1, 3'd4, 4'hD, 4'h7, 3, c_ST_SHR};
        vecs[8] = '{1'b0, 3'd3, 4'h0, 4'h0, 10'h000, 1'b0, 3'd0, 4'h0, 4'h7, 2, c_ST_SHR};
        vecs[9] = '{1'b1, 3'd3, 4'hE, 4'h0, 10'h0B0, 1'b0, 3'd0, 4'h0, 4'hE, 3, c_ST_MOD};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_data_out", {28'd0, data_out}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bus_out", {22'd0, bus_out}, 32'd0);
        check("rst_writeback", {31'd0, writeback}, 32'd0);
        check("rst_state", {30'd0, dut.r_line_state}, {30'd0, c_ST_INV});
        check("rst_hits", {24'd0, hit_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) run_vec(vecs[i]);

        // Snoop readMiss on the Modified line: writeback, downgrade to Shared
        @(negedge clock); bus_in = 10'h220;
        @(negedge clock); bus_in = '0;
        check("snoop_rm_wb", {31'd0, writeback}, 32'd1);
        check("snoop_rm_wb_addr", {29'd0, wb_address}, 32'd2);
        check("snoop_rm_wb_data", {28'd0, wb_data}, 32'hA);
        check("snoop_rm_state", {30'd0, dut.r_line_state}, {30'd0, c_ST_SHR});
        // Invalidate for a different tag leaves the line alone
        bus_in = 10'h0E0;
        @(negedge clock); bus_in = '0;
        check("wb_pulse_len", {31'd0, writeback}, 32'd0);
        check("snoop_miss_state", {30'd0, dut.r_line_state}, {30'd0, c_ST_SHR});

        for (int i = 3; i < 10; i++) run_vec(vecs[i]);

        // Write-hit commit in Modified collides with a writeMiss snoop for the same tag
        @(negedge clock);
        execute_instruction = 1'b1; instruction = 1'b1; address = 3'd3; data_in = 4'hF;
        sb.push_back(4'hF);
        @(negedge clock);
        execute_instruction = 1'b0; bus_in = 10'h130;
        @(negedge clock);
        bus_in = '0;
        check("stall_wb", {31'd0, writeback}, 32'd1);
        check("stall_wb_addr", {29'd0, wb_address}, 32'd3);
        check("stall_wb_data", {28'd0, wb_data}, 32'hE);
        check("stall_done", {31'd0, done}, 32'd0);
        check("stall_state", {30'd0, dut.r_line_state}, {30'd0, c_ST_INV});
        @(negedge clock);
        check("stall_bus", {22'd0, bus_out}, 32'h130);
        check("stall_no_wb", {31'd0, writeback}, 32'd0);
        fill_valid = 1'b1; fill_data = 4'h9;
        @(negedge clock);
        fill_valid = 1'b0;
        check("stall_done2", {31'd0, done}, 32'd1);
        check("stall_state2", {30'd0, dut.r_line_state}, {30'd0, c_ST_MOD});

`ifdef STATS_EN
        check("hit_count", {24'd0, hit_count}, 32'd7);
        check("miss_count", {24'd0, miss_count}, 32'd4);
`else
        check("hit_count", {24'd0, hit_count}, 32'd0);
        check("miss_count", {24'd0, miss_count}, 32'd0);
`endif

        // Reset while waiting for a fill: no completion, everything cleared
        @(negedge clock);
        execute_instruction = 1'b1; instruction = 1'b0; address = 3'd5;
        @(negedge clock);
        execute_instruction = 1'b0;
        @(negedge clock);
        check("midop_bus", {22'd0, bus_out}, 32'h250);
        reset = 1'b1;
        @(negedge clock);
        check("midop_done", {31'd0, done}, 32'd0);
        check("midop_bus_clr", {22'd0, bus_out}, 32'd0);
        check("midop_state", {30'd0, dut.r_line_state}, {30'd0, c_ST_INV});
        check("midop_fsm", {30'd0, dut.r_fsm}, 32'd0);
        check("midop_miss", {24'd0, miss_count}, 32'd0);
        reset = 1'b0;
        fill_valid = 1'b1; fill_data = 4'h1;
        repeat (3) @(negedge clock);
        fill_valid = 1'b0;
        check("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
